// File: rtl/qrng_request_arbiter.sv
// Harvests LFSR bits into WORD_W-bit words and hands each word to one requester, round-robin.
// Optional von Neumann debiasing of the harvested bits when RNG_WHITEN_EN is defined.
module qrng_request_arbiter #(
  parameter int          NUM_REQ   = 4,
  parameter int          WORD_W    = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_seed_load,
  input  logic [15:0]        i_seed_in,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_rnd_valid,
  output logic [WORD_W-1:0]  o_rnd_data,
  output logic               o_busy
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, HARVEST, OFFER} state_t;

  state_t             r_state, w_nextState;
  logic [15:0]        r_lfsr;
  logic [15:0]        w_lfsrAdv;
  logic [CNT_W-1:0]   r_cnt, w_nextCnt;
  logic [WORD_W-1:0]  r_word, w_nextWord;
  logic [PTR_W-1:0]   r_rrPtr, w_nextPtr, w_pick;
  logic               w_found;
  logic               w_bit, w_bitValid;
  logic [NUM_REQ-1:0] r_gnt, w_nextGnt;
  logic               r_valid, w_nextValid;
  logic [WORD_W-1:0]  r_data, w_nextData;

  function automatic logic [15:0] lfsrStep(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

`ifdef RNG_WHITEN_EN
  // Only unequal pairs carry an unbiased bit; the source advances two steps per cycle.
  assign w_bitValid = r_lfsr[1] ^ r_lfsr[0];
  assign w_bit      = r_lfsr[1];
  assign w_lfsrAdv  = lfsrStep(lfsrStep(r_lfsr));
`else
  assign w_bitValid = 1'b1;
  assign w_bit      = r_lfsr[0];
  assign w_lfsrAdv  = lfsrStep(r_lfsr);
`endif

  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_pick  = r_rrPtr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(r_rrPtr) + k) % NUM_REQ;
      if (!w_found && i_req[idx]) begin
        w_found = 1'b1;
        w_pick  = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextWord  = r_word;
    w_nextPtr   = r_rrPtr;
    w_nextGnt   = '0;
    w_nextValid = 1'b0;
    w_nextData  = '0;
    case (r_state)
      IDLE: begin
        if (i_en && |i_req) begin
          w_nextState = HARVEST;
          w_nextCnt   = '0;
          w_nextWord  = '0;
        end
      end
      HARVEST: begin
        if (i_en && w_bitValid) begin
          w_nextWord = {r_word[WORD_W-2:0], w_bit};
          w_nextCnt  = r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WORD_W - 1)) w_nextState = OFFER;
        end
      end
      OFFER: begin
        // With no requester the word simply waits here, so it is never lost or re-harvested.
        if (w_found) begin
          w_nextGnt[w_pick] = 1'b1;
          w_nextValid       = 1'b1;
          w_nextData        = r_word;
          w_nextPtr         = w_pick;
          w_nextState       = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_lfsr  <= LFSR_SEED;
      r_cnt   <= '0;
      r_word  <= '0;
      r_rrPtr <= PTR_W'(NUM_REQ - 1);
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_word  <= w_nextWord;
      r_rrPtr <= w_nextPtr;
      r_gnt   <= w_nextGnt;
      r_valid <= w_nextValid;
      r_data  <= w_nextData;
      if (i_seed_load)
        r_lfsr <= (i_seed_in == 16'h0000) ? LFSR_SEED : i_seed_in;
      else if (i_en)
        r_lfsr <= w_lfsrAdv;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_rnd_valid = r_valid;
  assign o_rnd_data  = r_data;
  assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_qrng_request_arbiter.sv
// Directed bench for qrng_request_arbiter: reset, latency, round-robin, enable stall,
// reseeding and mid-harvest reset, with a reference LFSR for the expected words.
module tb_qrng_request_arbiter;

  localparam int          WORD_W     = 8;
  localparam logic [15:0] SEED       = 16'hACE1;
  localparam logic [7:0]  FIRST_WORD = 8'hE4;
  localparam logic [7:0]  WORD_1234  = 8'h8D;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        en = 1'b1;
  logic        seedLoad = 1'b0;
  logic [15:0] seedIn = 16'h0000;
  logic [3:0]  req = 4'b0000;
  logic [3:0]  gnt;
  logic        rndValid;
  logic [7:0]  rndData;
  logic        busy;

  logic [15:0] mLfsr = SEED;
  int          compared = 0;
  int          mismatched = 0;

  qrng_request_arbiter #(.NUM_REQ(4), .WORD_W(WORD_W), .LFSR_SEED(SEED)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_en(en), .i_seed_load(seedLoad), .i_seed_in(seedIn),
    .i_req(req), .o_gnt(gnt), .o_rnd_valid(rndValid), .o_rnd_data(rndData), .o_busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] modelStep(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // One clock edge; the reference LFSR follows the inputs that were stable before the edge.
  task automatic step();
    @(posedge clk);
    if (!rstN) mLfsr = SEED;
    else if (seedLoad) mLfsr = (seedIn == 16'h0000) ? SEED : seedIn;
    else if (en) mLfsr = modelStep(mLfsr);
    #1;
  endtask

  task automatic doReset();
    rstN = 1'b0; req = 4'b0000; en = 1'b1; seedLoad = 1'b0;
    repeat (3) step();
    rstN = 1'b1;
  endtask

  // Raise req and run until a grant appears; harvest cycles are the ones after the IDLE cycle.
  task automatic runRequest(input logic [3:0] reqVal, input int pauseAt, input int pauseLen,
                            output int lat, output logic [3:0] g, output logic [7:0] d,
                            output logic [7:0] expW, output logic busySeen);
    int   got, paused;
    logic bitNow, enNow;
    got = 0; paused = 0; lat = -1; g = '0; d = '0; expW = '0; busySeen = 1'b0;
    req = reqVal;
    for (int n = 1; n <= 60 && lat < 0; n++) begin
      if (n >= 2 && got == pauseAt && paused < pauseLen) begin en = 1'b0; paused++; end
      else en = 1'b1;
      bitNow = mLfsr[0];
      enNow  = en;
      step();
      if (n >= 2 && enNow && got < WORD_W) begin expW = {expW[6:0], bitNow}; got++; end
      if (busy) busySeen = 1'b1;
      if (gnt != 4'b0000) begin lat = n; g = gnt; d = rndData; end
    end
    en = 1'b1;
  endtask

  task automatic test_reset();
    doReset();
    compared++; if (gnt !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt); end
    compared++; if (rndValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", rndValid); end
    compared++; if (rndData !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_data: got %h expected 00", rndData); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    int lat; logic [3:0] g; logic [7:0] d, expW; logic bs;
    doReset();
    runRequest(4'b0001, -1, 0, lat, g, d, expW, bs);
    compared++; if (lat != 10) begin mismatched++; $display("[TB] FAIL single_latency: got %0d expected 10", lat); end
    compared++; if (g !== 4'b0001) begin mismatched++; $display("[TB] FAIL single_gnt: got %b expected 0001", g); end
    compared++; if (d !== expW) begin mismatched++; $display("[TB] FAIL single_data_model: got %h expected %h", d, expW); end
    compared++; if (d !== FIRST_WORD) begin mismatched++; $display("[TB] FAIL single_data_const: got %h expected %h", d, FIRST_WORD); end
    compared++; if (bs !== 1'b1) begin mismatched++; $display("[TB] FAIL single_busy: got %b expected 1", bs); end
    req = 4'b0000;
    step();
    compared++; if (gnt !== 4'b0000) begin mismatched++; $display("[TB] FAIL single_gnt_pulse: got %b expected 0000", gnt); end
    compared++; if (rndValid !== 1'b0) begin mismatched++; $display("[TB] FAIL single_valid_pulse: got %b expected 0", rndValid); end
    compared++; if (rndData !== 8'h00) begin mismatched++; $display("[TB] FAIL single_data_clear: got %h expected 00", rndData); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL single_idle: got %b expected 0", busy); end
  endtask

  task automatic test_round_robin();
    int lat; logic [3:0] g, expG; logic [7:0] d, expW; logic bs;
    doReset();
    for (int i = 0; i < 5; i++) begin
      expG = 4'b0001 << (i % 4);
      runRequest(4'b1111, -1, 0, lat, g, d, expW, bs);
      compared++; if (g !== expG) begin mismatched++; $display("[TB] FAIL rr_gnt[%0d]: got %b expected %b", i, g, expG); end
      compared++; if (d !== expW) begin mismatched++; $display("[TB] FAIL rr_data[%0d]: got %h expected %h", i, d, expW); end
      compared++; if (lat != 10) begin mismatched++; $display("[TB] FAIL rr_latency[%0d]: got %0d expected 10", i, lat); end
      compared++; if (rndValid !== 1'b1) begin mismatched++; $display("[TB] FAIL rr_valid[%0d]: got %b expected 1", i, rndValid); end
    end
  endtask

  task automatic test_enable_pause();
    int lat; logic [3:0] g; logic [7:0] d, expW; logic bs;
    doReset();
    runRequest(4'b0001, 4, 5, lat, g, d, expW, bs);
    compared++; if (lat != 15) begin mismatched++; $display("[TB] FAIL pause_latency: got %0d expected 15", lat); end
    compared++; if (d !== FIRST_WORD) begin mismatched++; $display("[TB] FAIL pause_data_const: got %h expected %h", d, FIRST_WORD); end
    compared++; if (d !== expW) begin mismatched++; $display("[TB] FAIL pause_data_model: got %h expected %h", d, expW); end
  endtask

  task automatic test_seed_load();
    int lat; logic [3:0] g; logic [7:0] d, expW; logic bs;
    req = 4'b0000; seedLoad = 1'b1; seedIn = 16'h0000;
    step();
    seedLoad = 1'b0;
    runRequest(4'b0001, -1, 0, lat, g, d, expW, bs);
    compared++; if (g !== 4'b0001) begin mismatched++; $display("[TB] FAIL seed0_gnt: got %b expected 0001", g); end
    compared++; if (d !== FIRST_WORD) begin mismatched++; $display("[TB] FAIL seed0_data_const: got %h expected %h", d, FIRST_WORD); end
    compared++; if (d !== expW) begin mismatched++; $display("[TB] FAIL seed0_data_model: got %h expected %h", d, expW); end
    req = 4'b0000; seedLoad = 1'b1; seedIn = 16'h1234;
    step();
    seedLoad = 1'b0;
    runRequest(4'b0001, -1, 0, lat, g, d, expW, bs);
    compared++; if (lat != 10) begin mismatched++; $display("[TB] FAIL seed1234_latency: got %0d expected 10", lat); end
    compared++; if (d !== WORD_1234) begin mismatched++; $display("[TB] FAIL seed1234_data_const: got %h expected %h", d, WORD_1234); end
    compared++; if (d !== expW) begin mismatched++; $display("[TB] FAIL seed1234_data_model: got %h expected %h", d, expW); end
  endtask

  task automatic test_reset_mid_harvest();
    int lat; logic [3:0] g; logic [7:0] d, expW; logic bs, sawGnt;
    runRequest(4'b0010, -1, 0, lat, g, d, expW, bs);
    compared++; if (g !== 4'b0010) begin mismatched++; $display("[TB] FAIL midrst_pre_gnt: got %b expected 0010", g); end
    req = 4'b1111; sawGnt = 1'b0;
    repeat (5) begin step(); if (gnt != 4'b0000) sawGnt = 1'b1; end
    rstN = 1'b0;
    step();
    if (gnt != 4'b0000) sawGnt = 1'b1;
    compared++; if (sawGnt !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_no_gnt: got %b expected 0", sawGnt); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    rstN = 1'b1;
    runRequest(4'b1111, -1, 0, lat, g, d, expW, bs);
    compared++; if (g !== 4'b0001) begin mismatched++; $display("[TB] FAIL midrst_gnt: got %b expected 0001", g); end
    compared++; if (d !== FIRST_WORD) begin mismatched++; $display("[TB] FAIL midrst_data: got %h expected %h", d, FIRST_WORD); end
    compared++; if (lat != 10) begin mismatched++; $display("[TB] FAIL midrst_latency: got %0d expected 10", lat); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_enable_pause();
    test_seed_load();
    test_reset_mid_harvest();
    req = 4'b0000;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
